// File: rtl/width_8_32_arb.sv
// Round-robin byte arbiter feeding a width_8_32 packer; grants whole words.
// Optional per-requester burst counters: define ARB_STATS_EN.
module width_8_32_arb #(
  parameter int NUM_IN     = 4,
  parameter int WORD_BYTES = 4,
  localparam int SRC_W     = $clog2(NUM_IN)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_IN*8-1:0]    t_data,
  input  logic [NUM_IN-1:0]      t_valid,
  output logic [NUM_IN-1:0]      t_ready,
  output logic [7:0]             i0_data,
  output logic                   i0_valid,
  input  logic                   i0_ready,
  output logic [SRC_W-1:0]       i0_src,
  output logic                   i0_last,
`ifdef ARB_STATS_EN
  output logic [NUM_IN*32-1:0]   stats_words,
`endif
  output logic                   busy
);

  localparam int BW =
    (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       r_state;
  logic [SRC_W-1:0] r_gnt;
  logic [SRC_W-1:0] r_last_gnt;
  logic [BW-1:0]    r_bcnt;

  logic             w_grant;
  logic             w_hs;
  logic             w_end;
  logic             w_any;
  logic [SRC_W-1:0] w_pick_idle;
  logic [SRC_W-1:0] w_pick_re;

  // First valid requester after base, base itself last.
  function automatic logic [SRC_W-1:0] f_pick(
    input logic [SRC_W-1:0]  base,
    input logic [NUM_IN-1:0] v
  );
    logic [SRC_W-1:0] r;
    logic [SRC_W-1:0] idx;
    logic             hit;
    r   = base;
    hit = 1'b0;
    for (int i = 1; i <= NUM_IN; i++) begin
      idx = SRC_W'((int'(base) + i) % NUM_IN);
      if (!hit && v[idx]) begin
        hit = 1'b1;
        r   = idx;
      end
    end
    return r;
  endfunction

  assign w_grant     = (r_state == S_GRANT);
  assign w_any       = |t_valid;
  assign w_hs        = i0_valid & i0_ready;
  assign w_end       = (r_bcnt == BW'(WORD_BYTES - 1));
  assign w_pick_idle = f_pick(r_last_gnt, t_valid);
  assign w_pick_re   = f_pick(r_gnt, t_valid);

  // Steer the granted requester onto the packer port.
  always_comb begin
    i0_data  = '0;
    i0_valid = 1'b0;
    t_ready  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (r_gnt == SRC_W'(k)) begin
        i0_data  = t_data[k*8 +: 8];
        i0_valid = w_grant & t_valid[k];
        t_ready[k] = w_grant & i0_ready;
      end
    end
  end

  assign i0_src  = r_gnt;
  assign i0_last = w_grant & w_end;
  assign busy    = w_grant;

  // Arbitration FSM: hold a grant for one full word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_last_gnt <= SRC_W'(NUM_IN - 1);
      r_bcnt     <= '0;
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_gnt   <= w_pick_idle;
            r_bcnt  <= '0;
          end
        end
        (r_state == S_GRANT): begin
          if (w_hs) begin
            if (!w_end) begin
              r_bcnt <= r_bcnt + BW'(1);
            end else begin
              r_last_gnt <= r_gnt;
              r_bcnt     <= '0;
              if (w_any) begin
                r_gnt <= w_pick_re;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] r_stats [NUM_IN];

  // Count completed bursts per requester.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_IN; k++) begin
        r_stats[k] <= '0;
      end
    end else if (w_grant && w_hs && w_end) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (r_gnt == SRC_W'(k)) begin
          r_stats[k] <= r_stats[k] + 32'd1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_IN; k++) begin : g_st
    assign stats_words[32*k +: 32] = r_stats[k];
  end
`endif

endmodule

// File: tb/tb_width_8_32_arb.sv
// Directed bench for width_8_32_arb.
// Stats checks compile only with ARB_STATS_EN.
module tb_width_8_32_arb;

  typedef struct {
    logic [3:0]  tv;
    logic [31:0] d;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  es;
    logic        el;
    logic        eb;
    logic [3:0]  etr;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] t_data;
  logic [3:0]  t_valid;
  logic [3:0]  t_ready;
  logic [7:0]  i0_data;
  logic        i0_valid;
  logic        i0_ready;
  logic [1:0]  i0_src;
  logic        i0_last;
  logic        busy;
`ifdef ARB_STATS_EN
  logic [127:0] stats_words;
`endif

  int n_pass;
  int n_tot;

  width_8_32_arb #(.NUM_IN(4), .WORD_BYTES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .t_data      (t_data),
    .t_valid     (t_valid),
    .t_ready     (t_ready),
    .i0_data     (i0_data),
    .i0_valid    (i0_valid),
    .i0_ready    (i0_ready),
    .i0_src      (i0_src),
    .i0_last     (i0_last),
`ifdef ARB_STATS_EN
    .stats_words (stats_words),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic rst(input int n);
    @(negedge clk);
    reset_n  = 1'b0;
    t_valid  = 4'hf;
    t_data   = '0;
    i0_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst.busy",   busy,     0);
      chk("rst.valid",  i0_valid, 0);
      chk("rst.tready", t_ready,  0);
      chk("rst.last",   i0_last,  0);
      chk("rst.src",    i0_src,   0);
`ifdef ARB_STATS_EN
      chk("rst.stats",  stats_words, 0);
`endif
    end
  endtask

  task automatic cyc(input string nm, input vec_t v);
    @(negedge clk);
    reset_n  = 1'b1;
    t_valid  = v.tv;
    t_data   = v.d;
    i0_ready = v.rdy;
    #1;
    chk({nm, ".valid"},  i0_valid, v.ev);
    chk({nm, ".busy"},   busy,     v.eb);
    chk({nm, ".src"},    i0_src,   v.es);
    chk({nm, ".last"},   i0_last,  v.el);
    chk({nm, ".tready"}, t_ready,  v.etr);
    if (v.ev) chk({nm, ".data"}, i0_data, v.ed);
  endtask

  vec_t tbl [11];
  vec_t v;
  int   nb;
  int   rem0;
  int   rem2;

  initial begin
    n_pass   = 0;
    n_tot    = 0;
    reset_n  = 1'b0;
    t_valid  = '0;
    t_data   = '0;
    i0_ready = 1'b0;

    tbl[0]  = '{4'b0110, 32'h0055AA00, 1'b1,
                1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{4'b0110, 32'h0055AA00, 1'b1,
                1'b1, 8'hAA, 2'd1, 1'b0, 1'b1, 4'b0010};
    tbl[2]  = '{4'b0110, 32'h0055BB00, 1'b1,
                1'b1, 8'hBB, 2'd1, 1'b0, 1'b1, 4'b0010};
    for (int i = 3; i < 8; i++)
      tbl[i] = '{4'b0100, 32'h00550000, 1'b1,
                 1'b0, 8'h00, 2'd1, 1'b0, 1'b1, 4'b0010};
    tbl[8]  = '{4'b0110, 32'h0055CC00, 1'b1,
                1'b1, 8'hCC, 2'd1, 1'b0, 1'b1, 4'b0010};
    tbl[9]  = '{4'b0110, 32'h0055DD00, 1'b1,
                1'b1, 8'hDD, 2'd1, 1'b1, 1'b1, 4'b0010};
    tbl[10] = '{4'b0100, 32'h00550000, 1'b1,
                1'b1, 8'h55, 2'd2, 1'b0, 1'b1, 4'b0100};

    // reset with all valid, then round-robin fairness
    rst(3);
    cyc("fair.idle", '{4'hf, 32'hD3C2B1A0, 1'b1,
                       1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000});
    for (int k = 0; k < 32; k++) begin
      v.tv  = 4'hf;
      v.d   = 32'hD3C2B1A0;
      v.rdy = 1'b1;
      v.ev  = 1'b1;
      v.es  = 2'((k / 4) % 4);
      v.ed  = 8'hA0 + 8'h11 * 8'(v.es);
      v.el  = ((k % 4) == 3);
      v.eb  = 1'b1;
      v.etr = 4'b0001 << v.es;
      cyc("fair", v);
    end

    // word integrity across a valid gap
    rst(1);
    for (int i = 0; i < 11; i++) cyc("word", tbl[i]);

    // backpressure on a single requester
    rst(1);
    cyc("bp.idle", '{4'b1000, 32'h0, 1'b0,
                     1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000});
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      v.tv  = 4'b1000;
      v.d   = {8'h30 + 8'(nb), 24'h0};
      v.rdy = ((c % 2) == 0);
      v.ev  = 1'b1;
      v.ed  = 8'h30 + 8'(nb);
      v.es  = 2'd3;
      v.el  = ((nb % 4) == 3);
      v.eb  = 1'b1;
      v.etr = v.rdy ? 4'b1000 : 4'b0000;
      cyc("bp", v);
      if (v.rdy) nb++;
    end

    // reset mid-burst, then restart from byte 0
    rst(1);
    cyc("mid.idle", '{4'b0001, 32'h0, 1'b1,
                      1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000});
    for (int b = 0; b < 2; b++)
      cyc("mid.pre", '{4'b0001, 32'h40 + 32'(b), 1'b1,
                       1'b1, 8'h40 + 8'(b), 2'd0, 1'b0, 1'b1,
                       4'b0001});
    rst(1);
    cyc("mid.idle2", '{4'b0001, 32'h0, 1'b1,
                       1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000});
    for (int b = 0; b < 4; b++)
      cyc("mid.post", '{4'b0001, 32'h50 + 32'(b), 1'b1,
                        1'b1, 8'h50 + 8'(b), 2'd0, (b == 3), 1'b1,
                        4'b0001});

`ifdef ARB_STATS_EN
    rst(1);
    rem0 = 40;
    rem2 = 12;
    for (int c = 0; c < 300 && (rem0 > 0 || rem2 > 0); c++) begin
      @(negedge clk);
      reset_n  = 1'b1;
      t_data   = '0;
      i0_ready = 1'b1;
      t_valid  = {1'b0, rem2 > 0, 1'b0, rem0 > 0};
      #1;
      if (t_valid[0] && t_ready[0]) rem0--;
      if (t_valid[2] && t_ready[2]) rem2--;
    end
    @(posedge clk);
    #1;
    chk("stats.rem0", rem0, 0);
    chk("stats.rem2", rem2, 0);
    chk("stats.words", stats_words,
        {32'd0, 32'd3, 32'd0, 32'd10});
`else
    rem0 = 0;
    rem2 = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
